ahb_slave_mem: RTL

AHB_SLAVE_MEM -- requirements
Module: ahb_slave_mem

---
 rtl/ahb_pkg.sv | 51 +++++
 rtl/ahb_slave_mem_array.sv | 31 +++
 rtl/ahb_slave_mem.sv | 121 ++++++++++++
 3 files changed

// File: rtl/ahb_pkg.sv
// Shared AHB-lite definitions for slave blocks: transfer encodings, sizes, responses, slave FSM states.
package ahb_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_t;

    localparam logic [2:0] HSIZE_BYTE = 3'd0;
    localparam logic [2:0] HSIZE_HALF = 3'd1;
    localparam logic [2:0] HSIZE_WORD = 3'd2;

    localparam logic RESP_OKAY  = 1'b0;
    localparam logic RESP_ERROR = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_WAIT = 2'b01,
        ST_ERR1 = 2'b10,
        ST_ERR2 = 2'b11
    } slv_state_t;

    // Control half of a registered address phase
    typedef struct packed {
        logic       valid;
        logic       write;
        logic [2:0] size;
    } dphase_t;

    // Little-endian byte lanes touched by a transfer of the given size and low address bits
    function automatic logic [3:0] lane_mask(input logic [2:0] size, input logic [1:0] lo);
        case (size)
            HSIZE_BYTE: lane_mask = 4'b0001 << lo;
            HSIZE_HALF: lane_mask = lo[1] ? 4'b1100 : 4'b0011;
            default:    lane_mask = 4'b1111;
        endcase
    endfunction

    // Unsupported size or misaligned address
    function automatic logic xfer_err(input logic [2:0] size, input logic [1:0] lo);
        case (size)
            HSIZE_BYTE: xfer_err = 1'b0;
            HSIZE_HALF: xfer_err = lo[0];
            HSIZE_WORD: xfer_err = (lo != 2'b00);
            default:    xfer_err = 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/ahb_slave_mem_array.sv
// Word-organised storage with per-byte write enables and asynchronous word read; contents are not reset.
module ahb_slave_mem_array #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned WORD_AW    = 8
) (
    input  logic                    h_clk,
    input  logic                    we,
    input  logic [DATA_WIDTH/8-1:0] be,
    input  logic [WORD_AW-1:0]      addr,
    input  logic [DATA_WIDTH-1:0]   wdata,
    output logic [DATA_WIDTH-1:0]   rdata_c
);
    localparam int unsigned DEPTH     = 2 ** WORD_AW;
    localparam int unsigned NUM_LANES = DATA_WIDTH / 8;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Byte-lane write
    always_ff @(posedge h_clk) begin
        if (we) begin
            for (int i = 0; i < NUM_LANES; i++) begin
                if (be[i]) begin
                    mem[addr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

    assign rdata_c = mem[addr];

endmodule

// File: rtl/ahb_slave_mem.sv
// AHB-lite memory slave: pipelined address/data phases, optional fixed wait states, two-cycle ERROR response.
module ahb_slave_mem
    import ahb_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned ADDR_WIDTH  = 10,
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic                  h_clk,
    input  logic                  h_resetn,
    input  logic                  h_sel,
    input  logic [ADDR_WIDTH-1:0] h_addr,
    input  logic [1:0]            h_trans,
    input  logic                  h_write,
    input  logic [2:0]            h_size,
    input  logic [DATA_WIDTH-1:0] h_wdata,
    input  logic                  h_ready,
    output logic [DATA_WIDTH-1:0] h_rdata,
    output logic                  h_readyout,
    output logic                  h_resp
);
    localparam int unsigned CNT_W     = 3;
    localparam int unsigned WORD_AW   = ADDR_WIDTH - 2;
    localparam int unsigned NUM_LANES = DATA_WIDTH / 8;
    localparam logic [CNT_W-1:0] WAIT_LOAD = (WAIT_STATES == 0) ? '0 : CNT_W'(WAIT_STATES - 1);

    slv_state_t            state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    dphase_t               ph_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic                  ready_c, accept_c, req_err_c, final_c, we_c;
    logic [NUM_LANES-1:0]  be_c;
    logic [DATA_WIDTH-1:0] mem_rdata_c;

    // Address phases may only be taken in a cycle where this slave ends (or has no) data phase
    assign ready_c   = (state_q == ST_IDLE) || (state_q == ST_ERR2);
    assign accept_c  = h_sel && h_ready && ready_c &&
                       ((h_trans == HTRANS_NONSEQ) || (h_trans == HTRANS_SEQ));
    assign req_err_c = xfer_err(h_size, h_addr[1:0]);

    // Final cycle of an OKAY data phase: write commits, read data is presented
    assign final_c = (state_q == ST_IDLE) && ph_q.valid;
    assign we_c    = final_c && ph_q.write;
    assign be_c    = NUM_LANES'(lane_mask(ph_q.size, addr_q[1:0]));
    assign h_rdata = (final_c && !ph_q.write) ? mem_rdata_c : '0;

    // State and wait counter
    always_ff @(posedge h_clk or negedge h_resetn) begin
        if (!h_resetn) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Registered address phase; errored transfers never become valid data phases
    always_ff @(posedge h_clk or negedge h_resetn) begin
        if (!h_resetn) begin
            ph_q   <= '0;
            addr_q <= '0;
        end else if (ready_c) begin
            ph_q.valid <= accept_c && !req_err_c;
            if (accept_c) begin
                ph_q.write <= h_write;
                ph_q.size  <= h_size;
                addr_q     <= h_addr;
            end
        end
    end

    // Next state, counter and handshake outputs
    always_comb begin
        state_d    = ST_IDLE;
        cnt_d      = cnt_q;
        h_readyout = 1'b1;
        h_resp     = RESP_OKAY;
        case (state_q)
            ST_IDLE, ST_ERR2: begin
                if (state_q == ST_ERR2) begin
                    h_resp = RESP_ERROR;
                end
                if (accept_c) begin
                    if (req_err_c) begin
                        state_d = ST_ERR1;
                    end else if (WAIT_STATES != 0) begin
                        state_d = ST_WAIT;
                        cnt_d   = WAIT_LOAD;
                    end
                end
            end
            ST_WAIT: begin
                h_readyout = 1'b0;
                if (cnt_q != '0) begin
                    state_d = ST_WAIT;
                    cnt_d   = cnt_q - CNT_W'(1);
                end
            end
            ST_ERR1: begin
                h_readyout = 1'b0;
                h_resp     = RESP_ERROR;
                state_d    = ST_ERR2;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    ahb_slave_mem_array #(
        .DATA_WIDTH (DATA_WIDTH),
        .WORD_AW    (WORD_AW)
    ) u_array (
        .h_clk   (h_clk),
        .we      (we_c),
        .be      (be_c),
        .addr    (addr_q[ADDR_WIDTH-1:2]),
        .wdata   (h_wdata),
        .rdata_c (mem_rdata_c)
    );

endmodule
